// File: rtl/slc3_io_pkg.sv
// Shared types and constants for the SLC-3 board input front end.
package slc3_io_pkg;

  typedef enum logic [1:0] {REL, REL_CHK, PRS, PRS_CHK} deb_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_SIM = 4;

endpackage

// File: rtl/slc3_input_conditioner_key_debounce.sv
// One pushbutton channel: 2-flop synchroniser, debounce FSM and stability counter.
module key_debounce
  import slc3_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("key_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          sync1, sync2;
  logic          ks;
  logic [CW-1:0] cnt;
  deb_state_e    state;

  // Synchroniser holds the raw active-low level, so it resets to released (1).
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign ks = ~sync2;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= REL;
      cnt         <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      case (state)
        REL: begin
          if (ks) begin
            state <= REL_CHK;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        REL_CHK: begin
          if (!ks) begin
            state <= REL;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state     <= PRS;
            cnt       <= '0;
            key_level <= 1'b1;
            key_press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRS: begin
          if (!ks) begin
            state <= PRS_CHK;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        PRS_CHK: begin
          if (ks) begin
            state <= PRS;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state       <= REL;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_release <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= REL;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/slc3_input_conditioner.sv
// Board input front end: per-KEY debounce channels plus a 2-flop switch synchroniser.
module slc3_input_conditioner
  import slc3_io_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 2,
  parameter int unsigned SW_WIDTH        = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [NUM_KEYS-1:0] KEY_n,
  input  logic [SW_WIDTH-1:0] SW_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [SW_WIDTH-1:0] SW_sync
);

  logic [SW_WIDTH-1:0] sw_meta;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .Clk        (Clk),
      .Reset      (Reset),
      .key_n      (KEY_n[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i])
    );
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sw_meta <= '0;
      SW_sync <= '0;
    end else begin
      sw_meta <= SW_raw;
      SW_sync <= sw_meta;
    end
  end

endmodule

// File: tb/tb_slc3_input_conditioner.sv
// Scoreboard bench: run-length reference model predicts every output each cycle.
module tb_slc3_input_conditioner;
  import slc3_io_pkg::*;

  localparam int NK = 2;
  localparam int SWW = 10;
  localparam int D = DEBOUNCE_CYCLES_SIM;

  logic           Clk = 1'b0;
  logic           Reset;
  logic [NK-1:0]  KEY_n;
  logic [SWW-1:0] SW_raw;
  logic [NK-1:0]  key_level, key_press, key_release;
  logic [SWW-1:0] SW_sync;

  slc3_input_conditioner #(
    .NUM_KEYS       (NK),
    .SW_WIDTH       (SWW),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .KEY_n      (KEY_n),
    .SW_raw     (SW_raw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .SW_sync    (SW_sync)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [NK-1:0]  lvl;
    logic [NK-1:0]  prs;
    logic [NK-1:0]  rel;
    logic [SWW-1:0] sw;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   press_cnt[NK];
  int   release_cnt[NK];

  // Reference model: a key's accepted level flips once its pressed state, seen
  // two edges late, has disagreed with that level for D+1 consecutive samples.
  logic [NK-1:0]  m_lvl;
  int             m_run[NK];
  logic [NK-1:0]  kq[$];
  logic [SWW-1:0] m_swprev;

  task automatic model_reset();
    m_lvl = '0;
    for (int i = 0; i < NK; i++) m_run[i] = 0;
    kq.delete();
    kq.push_back('0);
    kq.push_back('0);
    m_swprev = '0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge Clk) begin : model
    exp_t e;
    logic [NK-1:0] s;
    if (Reset) begin
      model_reset();
      e = '0;
    end else begin
      e.prs = '0;
      e.rel = '0;
      s = kq.pop_front();
      kq.push_back(~KEY_n);
      for (int i = 0; i < NK; i++) begin
        if (s[i] != m_lvl[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_run[i] == D + 1) begin
          m_lvl[i] = ~m_lvl[i];
          m_run[i] = 0;
          if (m_lvl[i]) e.prs[i] = 1'b1;
          else e.rel[i] = 1'b1;
        end
      end
      e.lvl = m_lvl;
      e.sw = m_swprev;
      m_swprev = SW_raw;
    end
    sb.push_back(e);
  end

  always @(posedge Clk) begin : monitor
    exp_t e;
    #1;
    for (int i = 0; i < NK; i++) begin
      press_cnt[i] += int'(key_press[i]);
      release_cnt[i] += int'(key_release[i]);
    end
    if (sb.size() == 0) begin
      check("scoreboard_entry", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("key_level", 32'(key_level), 32'(e.lvl));
      check("key_press", 32'(key_press), 32'(e.prs));
      check("key_release", 32'(key_release), 32'(e.rel));
      check("SW_sync", 32'(SW_sync), 32'(e.sw));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  initial begin : stim
    int p0, p1, r1, lat;
    int hold[NK];
    for (int i = 0; i < NK; i++) begin
      press_cnt[i] = 0;
      release_cnt[i] = 0;
    end
    model_reset();
    Reset = 1'b1;
    KEY_n = '1;
    SW_raw = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("reset_level", 32'(key_level), 32'd0);
    check("reset_sw", 32'(SW_sync), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    cycles(20);
    check("idle_no_press", 32'(press_cnt[0] + press_cnt[1]), 32'd0);

    // Run key held: one press, fixed latency
    p0 = press_cnt[0];
    p1 = press_cnt[1];
    KEY_n[0] = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge Clk);
      #1;
      if (key_level[0]) begin
        lat = c;
        break;
      end
    end
    check("press_latency", 32'(lat), 32'(D + 3));
    cycles(20);
    check("held_single_press", 32'(press_cnt[0] - p0), 32'd1);
    check("other_key_idle", 32'(press_cnt[1] - p1), 32'd0);
    KEY_n[0] = 1'b1;
    cycles(15);

    // Short bounce on Continue is rejected
    p1 = press_cnt[1];
    KEY_n[1] = 1'b0;
    cycles(3);
    KEY_n[1] = 1'b1;
    cycles(20);
    check("bounce_rejected", 32'(press_cnt[1] - p1), 32'd0);

    // Press then release Continue
    r1 = release_cnt[1];
    KEY_n[1] = 1'b0;
    cycles(10);
    KEY_n[1] = 1'b1;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge Clk);
      #1;
      if (key_release[1]) begin
        lat = c;
        break;
      end
    end
    check("release_latency", 32'(lat), 32'(D + 3));
    cycles(10);
    check("cont_press", 32'(press_cnt[1] - p1), 32'd1);
    check("cont_release", 32'(release_cnt[1] - r1), 32'd1);

    // Simultaneous press interrupted by reset, then re-qualified
    p0 = press_cnt[0];
    p1 = press_cnt[1];
    KEY_n = '0;
    cycles(4);
    Reset = 1'b1;
    cycles(2);
    Reset = 1'b0;
    check("reset_discard", 32'(press_cnt[0] + press_cnt[1] - p0 - p1), 32'd0);
    cycles(15);
    check("requal_press0", 32'(press_cnt[0] - p0), 32'd1);
    check("requal_press1", 32'(press_cnt[1] - p1), 32'd1);
    KEY_n = '1;
    cycles(15);

    // Switch synchroniser
    SW_raw = 10'h003;
    cycles(4);
    check("sw_003", 32'(SW_sync), 32'h003);
    SW_raw = 10'h005;
    cycles(4);
    check("sw_005", 32'(SW_sync), 32'h005);
    Reset = 1'b1;
    #1;
    check("sw_reset", 32'(SW_sync), 32'h000);
    cycles(2);
    Reset = 1'b0;
    cycles(5);

    // Randomised bouncing keys, switches and occasional resets
    for (int i = 0; i < NK; i++) hold[i] = 0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge Clk);
      for (int i = 0; i < NK; i++) begin
        if (hold[i] == 0) begin
          KEY_n[i] = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 12);
        end
        hold[i]--;
      end
      SW_raw = SWW'($urandom);
      Reset = ($urandom_range(0, 299) == 0);
    end
    @(negedge Clk);
    Reset = 1'b0;
    KEY_n = '1;
    cycles(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
